// File: rtl/route_arb_pkg.sv
// Shared types and constants for the route-header arbiter.
package route_arb_pkg;

    localparam int PKT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// Minimal AXI-Stream bundle shared by requesters and the merged output.
interface axi_stream_inf #(
    parameter int DSIZE = 8
);
    localparam int KSIZE = (DSIZE + 7) / 8;

    logic             aclken;
    logic             tvalid;
    logic             tready;
    logic [DSIZE-1:0] tdata;
    logic [KSIZE-1:0] tkeep;
    logic             tuser;
    logic             tlast;

    modport master (input aclken, tready, output tvalid, tdata, tkeep, tuser, tlast);
    modport slaver (input tvalid, tdata, tkeep, tuser, tlast, output tready);

endinterface

// File: rtl/route_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module route_rr_pick #(
    parameter int NUM = 4,
    parameter int IW  = $clog2(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NUM-1:0] grant,
    output logic [IW-1:0]  index,
    output logic           found
);

    logic [NUM-1:0] rot;
    logic [IW:0]    sum;

    always_comb begin
        rot   = NUM'({req, req} >> ptr);
        grant = '0;
        index = '0;
        found = 1'b0;
        sum   = '0;
        // Descending scan so the smallest offset from ptr wins.
        for (int k = NUM - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW + 1)'(k);
            end
        end
        if (sum >= (IW + 1)'(NUM)) begin
            sum = sum - (IW + 1)'(NUM);
        end
        index = sum[IW-1:0];
        if (found) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_stream_route_head_arbiter.sv
// Packet-level round-robin merge of NUM streams, prefixing each packet with a route header.
// Optional per-requester packet counters: define ROUTE_ARB_PKT_CNT_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin
// HEAD  | emit HEAD_DUMMY header beats carrying grant_id (MSB beat first)
// BODY  | forward granted stream until its tlast handshake
module axi_stream_route_head_arbiter
    import route_arb_pkg::*;
#(
    parameter int NUM        = 4,
    parameter int HEAD_DUMMY = 4,
    parameter int DSIZE      = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi_stream_inf.slaver          sub_rx_inf [NUM-1:0],
    axi_stream_inf.master          master,
    output logic [$clog2(NUM)-1:0] grant_id,
    output logic                   busy
`ifdef ROUTE_ARB_PKT_CNT_EN
    ,
    output logic [NUM*PKT_CNT_W-1:0] pkt_cnt
`endif
);

    localparam int IW    = $clog2(NUM);
    localparam int KSIZE = (DSIZE + 7) / 8;
    localparam int HW    = DSIZE * HEAD_DUMMY;
    localparam int CW    = (HEAD_DUMMY > 1) ? $clog2(HEAD_DUMMY) : 1;

    logic [NUM-1:0]   rx_valid;
    logic [NUM-1:0]   rx_last;
    logic [NUM-1:0]   rx_user;
    logic [NUM-1:0]   rx_ready;
    logic [DSIZE-1:0] rx_data [NUM];
    logic [KSIZE-1:0] rx_keep [NUM];

    for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
        assign rx_valid[gi]          = sub_rx_inf[gi].tvalid;
        assign rx_last[gi]           = sub_rx_inf[gi].tlast;
        assign rx_user[gi]           = sub_rx_inf[gi].tuser;
        assign rx_data[gi]           = sub_rx_inf[gi].tdata;
        assign rx_keep[gi]           = sub_rx_inf[gi].tkeep;
        assign sub_rx_inf[gi].tready = rx_ready[gi];
    end

    // Clock enable on the merged side is intentionally not honoured.
    logic unused_aclken;
    assign unused_aclken = master.aclken;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   head_cnt_q, head_cnt_d;
    logic [NUM-1:0]  pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [HW-1:0]   head_vec;
    logic [DSIZE-1:0] head_beat;
    logic            body_done;

    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic [KSIZE-1:0] m_keep;
    logic             m_user;
    logic             m_last;

    route_rr_pick #(
        .NUM (NUM),
        .IW  (IW)
    ) u_pick (
        .req   (rx_valid),
        .ptr   (rr_q),
        .grant (pick_grant),
        .index (pick_idx),
        .found (pick_found)
    );

    assign head_vec  = HW'(grant_q);
    assign head_beat = DSIZE'(head_vec >> (DSIZE * (HEAD_DUMMY - 1 - int'(head_cnt_q))));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            head_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            head_cnt_q <= head_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        head_cnt_d = head_cnt_q;
        m_valid    = 1'b0;
        m_data     = '0;
        m_keep     = '0;
        m_user     = 1'b0;
        m_last     = 1'b0;
        rx_ready   = '0;
        body_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    rr_d       = IW'(wrap_inc(int'(pick_idx), NUM));
                    head_cnt_d = '0;
                    state_d    = HEAD;
                end
            end
            HEAD: begin
                m_valid = 1'b1;
                m_data  = head_beat;
                m_keep  = '1;
                if (master.tready) begin
                    if (head_cnt_q == CW'(HEAD_DUMMY - 1)) begin
                        head_cnt_d = '0;
                        state_d    = BODY;
                    end else begin
                        head_cnt_d = head_cnt_q + 1'b1;
                    end
                end
            end
            BODY: begin
                m_valid           = rx_valid[grant_q];
                m_data            = rx_data[grant_q];
                m_keep            = rx_keep[grant_q];
                m_user            = rx_user[grant_q];
                m_last            = rx_last[grant_q];
                rx_ready[grant_q] = master.tready;
                if (rx_valid[grant_q] && master.tready && rx_last[grant_q]) begin
                    body_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign master.tvalid = m_valid;
    assign master.tdata  = m_data;
    assign master.tkeep  = m_keep;
    assign master.tuser  = m_user;
    assign master.tlast  = m_last;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);

`ifdef ROUTE_ARB_PKT_CNT_EN
    logic [NUM*PKT_CNT_W-1:0] pkt_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt_q <= '0;
        end else if (body_done && (pkt_cnt_q[grant_q*PKT_CNT_W +: PKT_CNT_W] != {PKT_CNT_W{1'b1}})) begin
            pkt_cnt_q[grant_q*PKT_CNT_W +: PKT_CNT_W] <= pkt_cnt_q[grant_q*PKT_CNT_W +: PKT_CNT_W] + 1'b1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axi_stream_route_head_arbiter.sv
// Directed bench for axi_stream_route_head_arbiter (NUM=4, HEAD_DUMMY=4, DSIZE=8).
module tb_axi_stream_route_head_arbiter;

    localparam int NUM = 4;
    localparam int DS  = 8;

    typedef struct packed {
        logic [3:0] gap;
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
        logic        last;
        logic [1:0]  gid;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_stream_inf #(.DSIZE(DS)) sub_if [NUM-1:0] ();
    axi_stream_inf #(.DSIZE(DS)) m_if ();

    logic       m_ready;
    logic [1:0] grant_id;
    logic       busy;
`ifdef ROUTE_ARB_PKT_CNT_EN
    logic [63:0] pkt_cnt;
`endif

    beat_t q [NUM][$];
    ent_t  log_q [$];
    ent_t  exp_q [$];
    bit    flush  = 1'b0;
    bit    tog    = 1'b0;
    bit    watch3 = 1'b0;
    int    viol   = 0;
    int    cyc    = 0;
    int    n_cmp  = 0;
    int    n_err  = 0;

    assign m_if.tready = m_ready;
    assign m_if.aclken = 1'b1;

    for (genvar g = 0; g < NUM; g++) begin : g_drv
        logic       v;
        logic       l;
        logic [7:0] d;
        bit         hs;
        bit         gap_done;
        int         gapc;

        assign sub_if[g].tvalid = v;
        assign sub_if[g].tdata  = d;
        assign sub_if[g].tlast  = l;
        assign sub_if[g].tkeep  = 1'b1;
        assign sub_if[g].tuser  = 1'b0;
        assign sub_if[g].aclken = 1'b1;

        initial begin
            hs = 1'b0;
            forever begin
                @(negedge clk);
                hs = v && sub_if[g].tready;
            end
        end

        initial begin
            v = 1'b0; l = 1'b0; d = 8'h00; gapc = 0; gap_done = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (flush) begin
                    q[g].delete();
                    gapc = 0; gap_done = 1'b0; v = 1'b0;
                end else begin
                    if (hs) begin
                        void'(q[g].pop_front());
                        gapc = 0; gap_done = 1'b0;
                    end
                    if (q[g].size() == 0) begin
                        v = 1'b0;
                    end else if (!gap_done && gapc < int'(q[g][0].gap)) begin
                        v = 1'b0;
                        gapc++;
                    end else begin
                        v = 1'b1; d = q[g][0].data; l = q[g][0].last; gap_done = 1'b1;
                    end
                end
            end
        end
    end

    axi_stream_route_head_arbiter #(
        .NUM        (NUM),
        .HEAD_DUMMY (4),
        .DSIZE      (DS)
    ) dut (
        .aclk       (clk),
        .aresetn    (rst_n),
        .sub_rx_inf (sub_if),
        .master     (m_if),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef ROUTE_ARB_PKT_CNT_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = tog ? ~m_ready : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && m_if.tvalid && m_ready)
                log_q.push_back('{32'(cyc), m_if.tdata, m_if.tlast, grant_id});
            if (watch3 && busy && grant_id == 2'd0 && sub_if[3].tready)
                viol++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int s, input logic [7:0] d, input logic l, input int gap);
        q[s].push_back('{4'(gap), d, l});
    endtask

    task automatic exp_beat(input logic [7:0] d, input logic l, input logic [1:0] gid);
        exp_q.push_back('{32'd0, d, l, gid});
    endtask

    task automatic exp_head(input logic [1:0] gid);
        exp_beat(8'h00, 1'b0, gid);
        exp_beat(8'h00, 1'b0, gid);
        exp_beat(8'h00, 1'b0, gid);
        exp_beat({6'd0, gid}, 1'b0, gid);
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (log_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_beats"}, 32'(log_q.size()), 32'(n));
    endtask

    task automatic check_log(input string tag);
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(log_q[i].data), 32'(exp_q[i].data));
            check($sformatf("%s_last%0d", tag, i), 32'(log_q[i].last), 32'(exp_q[i].last));
            check($sformatf("%s_gid%0d", tag, i), 32'(log_q[i].gid), 32'(exp_q[i].gid));
        end
        exp_q.delete();
        log_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
        log_q.delete();
    endtask

    initial begin
        int t;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_tdata", 32'(m_if.tdata), 32'd0);
        check("rst_tready", 32'({sub_if[3].tready, sub_if[2].tready, sub_if[1].tready, sub_if[0].tready}), 32'd0);
        rst_n = 1'b1;

        // single 3-beat packet from sub 2
        @(negedge clk);
        send(2, 8'hAA, 1'b0, 0);
        send(2, 8'hBB, 1'b0, 0);
        send(2, 8'hCC, 1'b1, 0);
        exp_head(2'd2);
        exp_beat(8'hAA, 1'b0, 2'd2);
        exp_beat(8'hBB, 1'b0, 2'd2);
        exp_beat(8'hCC, 1'b1, 2'd2);
        wait_beats("t1", 7, 60);
        check_log("t1");

        // all four requesting: round-robin from 0 with one idle cycle between packets
        do_reset();
        for (int s = 0; s < NUM; s++)
            for (int p = 0; p < 2; p++) begin
                send(s, 8'((s << 4) | (p * 2)), 1'b0, 0);
                send(s, 8'((s << 4) | (p * 2 + 1)), 1'b1, 0);
            end
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NUM; s++) begin
                exp_head(2'(s));
                exp_beat(8'((s << 4) | (p * 2)), 1'b0, 2'(s));
                exp_beat(8'((s << 4) | (p * 2 + 1)), 1'b1, 2'(s));
            end
        wait_beats("t2", 48, 600);
        for (int k = 0; k < 7; k++)
            check($sformatf("t2_gap%0d", k), log_q[k*6+6].cyc - log_q[k*6+5].cyc, 32'd2);
        check_log("t2");

        // master.tready toggling through header and body
        tog = 1'b1;
        @(negedge clk);
        send(1, 8'h11, 1'b0, 0);
        send(1, 8'h22, 1'b0, 0);
        send(1, 8'h33, 1'b1, 0);
        exp_head(2'd1);
        exp_beat(8'h11, 1'b0, 2'd1);
        exp_beat(8'h22, 1'b0, 2'd1);
        exp_beat(8'h33, 1'b1, 2'd1);
        wait_beats("t3", 7, 120);
        check_log("t3");
        tog = 1'b0;
        repeat (2) @(negedge clk);

        // granted sub 0 stalls 5 cycles mid-packet while sub 3 waits
        send(0, 8'h50, 1'b0, 0);
        send(0, 8'h51, 1'b0, 5);
        send(0, 8'h52, 1'b1, 0);
        t = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t4_busy", 32'(busy), 32'd1);
        viol   = 0;
        watch3 = 1'b1;
        send(3, 8'h70, 1'b1, 0);
        exp_head(2'd0);
        exp_beat(8'h50, 1'b0, 2'd0);
        exp_beat(8'h51, 1'b0, 2'd0);
        exp_beat(8'h52, 1'b1, 2'd0);
        exp_head(2'd3);
        exp_beat(8'h70, 1'b1, 2'd3);
        wait_beats("t4", 12, 150);
        watch3 = 1'b0;
        check("t4_sub3_ready", 32'(viol), 32'd0);
        check("t4_stall", log_q[5].cyc - log_q[4].cyc, 32'd6);
        check_log("t4");

        // reset during the second header beat
        send(2, 8'h61, 1'b0, 0);
        send(2, 8'h62, 1'b1, 0);
        t = 0;
        while (!m_if.tvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t5_head0", 32'(m_if.tvalid), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_tvalid", 32'(m_if.tvalid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_grant", 32'(grant_id), 32'd0);
        check("t5_tdata", 32'(m_if.tdata), 32'd0);
        check("t5_tready", 32'({sub_if[3].tready, sub_if[2].tready, sub_if[1].tready, sub_if[0].tready}), 32'd0);
        flush = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
        log_q.delete();
        @(negedge clk);
        send(0, 8'h9A, 1'b1, 0);
        send(3, 8'hB3, 1'b0, 0);
        send(3, 8'hB4, 1'b1, 0);
        exp_head(2'd0);
        exp_beat(8'h9A, 1'b1, 2'd0);
        exp_head(2'd3);
        exp_beat(8'hB3, 1'b0, 2'd3);
        exp_beat(8'hB4, 1'b1, 2'd3);
        wait_beats("t5", 11, 120);
        check_log("t5");

`ifdef ROUTE_ARB_PKT_CNT_EN
        // per-requester packet counters and saturation
        do_reset();
        for (int p = 0; p < 3; p++) begin
            send(1, 8'(8'h40 + p), 1'b0, 0);
            send(1, 8'(8'h48 + p), 1'b1, 0);
        end
        wait_beats("t6", 18, 200);
        log_q.delete();
        check("t6_cnt1", 32'(pkt_cnt[31:16]), 32'd3);
        check("t6_cnt0", 32'(pkt_cnt[15:0]), 32'd0);
        check("t6_cnt2", 32'(pkt_cnt[47:32]), 32'd0);
        check("t6_cnt3", 32'(pkt_cnt[63:48]), 32'd0);
        force dut.pkt_cnt_q = 64'h0000_0000_FFFF_0000;
        @(negedge clk);
        release dut.pkt_cnt_q;
        @(negedge clk);
        send(1, 8'h4F, 1'b1, 0);
        wait_beats("t6b", 5, 60);
        log_q.delete();
        check("t6_sat", 32'(pkt_cnt[31:16]), 32'h0000FFFF);
        check("t6_sat_cnt0", 32'(pkt_cnt[15:0]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_stream_route_head_arbiter.md
AXI_STREAM_ROUTE_HEAD_ARBITER -- requirements
Module: axi_stream_route_head_arbiter

Interface
REQ-001 SHALL have parameter NUM, default 4: number of upstream requesters, 2..16.
REQ-002 SHALL have parameter HEAD_DUMMY, default 4: route header length in beats, at least 1.
REQ-003 SHALL have parameter DSIZE, default 8: beat width, which SHALL equal the DSIZE of every connected interface.
REQ-004 SHALL have ports: aclk input 1: the single clock; all interfaces are synchronous to it.
REQ-005 SHALL have ports: aresetn input 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports: sub_rx_inf[NUM-1:0] axi_stream_inf.slaver DSIZE: requester packet streams.
REQ-007 SHALL have ports: master axi_stream_inf.master DSIZE: merged stream, with a route header before each packet.
REQ-008 SHALL have ports: grant_id output $clog2(NUM): index of the requester currently owning master.
REQ-009 SHALL have ports: busy output 1: high outside IDLE.

Function
REQ-010 SHALL arbitrate at packet granularity through FSM states IDLE, HEAD and BODY.
REQ-011 IDLE: SHALL select the first sub_rx_inf[i] with tvalid=1, searching round-robin from rr_ptr; on a pick, SHALL register grant_id=i and rr_ptr=(i+1) mod NUM, then go to HEAD on the next cycle.
REQ-012 IDLE with no request SHALL hold state and rr_ptr.
REQ-013 IDLE: the arbitration decision SHALL take 1 cycle; the first header beat SHALL appear on the cycle after the pick.
REQ-014 HEAD: SHALL drive master.tvalid=1 for HEAD_DUMMY beats with tkeep all-ones and tlast=0.
REQ-015 HEAD: the header field SHALL be DSIZE*HEAD_DUMMY bits holding grant_id zero-extended, sent big-endian (MSB beat first); the final header beat therefore carries grant_id in its LSBs.
REQ-016 HEAD: the beat counter SHALL advance only on master tvalid&&tready and go to BODY after beat HEAD_DUMMY-1.
REQ-017 HEAD: all sub_rx_inf tready SHALL be 0.
REQ-018 BODY: SHALL pass the granted stream combinationally: tvalid, tdata, tkeep, tuser and tlast forwarded to master; granted tready = master.tready.
REQ-019 BODY: every non-granted tready SHALL be 0.
REQ-020 BODY: on a granted tvalid&&tready&&tlast handshake, SHALL return to IDLE; the next arbitration SHALL start the following cycle, giving a 1-cycle bubble between packets.
REQ-021 A requester deasserting tvalid mid-packet SHALL NOT lose the grant; the block SHALL wait indefinitely.
REQ-022 Simultaneous requests SHALL be served in round-robin order; no requester SHALL wait more than NUM-1 packets.
REQ-023 rr_ptr SHALL wrap from NUM-1 to 0.
REQ-024 A single-beat packet (tlast on its first beat) SHALL produce a header followed by one body beat.
REQ-025 master.aclken SHALL be ignored; all logic SHALL run every aclk cycle.

Reset
REQ-026 On aresetn=0 the block SHALL immediately enter IDLE with: rr_ptr=0, grant_id=0, head counter=0, busy=0, master tvalid/tlast=0, tdata=0, all sub_rx_inf tready=0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet with no residual header state; the bench SHALL flush the upstreams.

Configuration
REQ-028 With ROUTE_ARB_PKT_CNT_EN defined, SHALL add output pkt_cnt[NUM*16-1:0], one saturating 16-bit counter per requester.
REQ-029 With ROUTE_ARB_PKT_CNT_EN defined, counter i SHALL increment on each completed BODY tlast handshake of requester i, and all counters SHALL reset to 0.
REQ-030 Without ROUTE_ARB_PKT_CNT_EN, the port and counters SHALL be absent and the function otherwise identical.

Structure
REQ-031 Package route_arb_pkg SHALL hold the state enum (IDLE, HEAD, BODY) and the counter-width constant PKT_CNT_W=16.
REQ-032 Round-robin selection SHALL be the sub-module route_rr_pick (req vector, ptr in; onehot grant, index, found out), purely combinational.
REQ-033 The block SHALL be the upstream pair of axi_stream_interconnect_S2M_auto with equal NUM and HEAD_DUMMY; the loopback SHALL reproduce each packet on sub_tx_inf[grant_id].

Verification
REQ-034 NUM=4, HEAD_DUMMY=4, DSIZE=8; sub 2 sends a 3-beat packet AA,BB,CC -> master carries 00,00,00,02,AA,BB,CC with tlast on CC only, and grant_id=2.
REQ-035 All 4 subs valid continuously with 2-beat packets -> grant order 0,1,2,3,0; 1-cycle idle gap after each tlast.
REQ-036 master.tready toggling 1,0 during HEAD and BODY -> no beat dropped or duplicated, and header count stays at 4.
REQ-037 Granted sub drops tvalid for 5 cycles mid-packet while sub 3 is valid -> sub 3 tready stays 0 and the grant is held until tlast.
REQ-038 aresetn pulsed low during the second header beat -> tvalid=0 and busy=0 in the same cycle; after release the next request gets a fresh 4-beat header and rr_ptr=0.
REQ-039 ROUTE_ARB_PKT_CNT_EN defined; 3 packets from sub 1 -> pkt_cnt[31:16]=3 and the other counters = 0; counter preset to FFFF stays at FFFF.
